// File: rtl/enc_scan_ctrl.sv
// enc_scan_ctrl: time-shared quadrature decoder for N_CH rotary encoders.
// One channel is visited per prescaler tick (IDLE -> SAMPLE -> UPDATE). Each
// visit updates that channel's position count and posts detent-change events.
// A round-robin arbiter drains the events through one valid/ready port.
// Optional build macro: ENC_SAT_EN -- counts saturate at 0 and all-ones
// instead of wrapping modulo 2^CNT_W.
module enc_scan_ctrl #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         enc_a,
    input  logic [N_CH-1:0]         enc_b,
    input  logic [N_CH-1:0]         ch_clr,
    input  logic [$clog2(N_CH)-1:0] rd_ch,
    output logic [CNT_W-3:0]        rd_value,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_dir,
    output logic                    evt_lost,
    output logic [7:0]              err_cnt
);
    // Event port: evt_ch/evt_dir are meaningful while evt_valid=1 and stay
    // stable until the cycle in which evt_valid & evt_ready both hold; that
    // cycle is the transfer, and the register may reload on the same edge.

    localparam int CH_W = $clog2(N_CH);
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_UPDATE} state_t;

    // Gray-coded AB phase to a binary position: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_a_q, sync_b_q;
    logic [N_CH-1:0]  a_s, b_s;

    logic [PS_W-1:0]  presc_q, presc_d;
    logic             tick;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [1:0]       cur_ab_q, cur_ab_d;

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [1:0]       prev_q [N_CH];
    logic [1:0]       prev_d [N_CH];
    logic [N_CH-1:0]  seen_q, seen_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  dir_q, dir_d;

    logic [7:0]       err_q, err_d;
    logic             lost_q, lost_d, lost_set;
    logic [CH_W-1:0]  last_q, last_d;
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic             evt_dir_q, evt_dir_d;

    logic [1:0]       prev_sel, pos_diff;
    logic [CNT_W-1:0] cnt_sel, cnt_new;
    logic             do_upd, step_up, step_dn, illegal, cnt_step, detent_chg;

    logic             arb_found, load_en, drain;
    logic [CH_W-1:0]  arb_sel, cand;

    logic [CNT_W-3:0] rd_tab [2**CH_W];

    // Input synchronisers: shift raw A/B through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b};
        end
    end

    assign a_s     = sync_a_q[SYNC_STAGES-1];
    assign b_s     = sync_b_q[SYNC_STAGES-1];
    assign tick    = (presc_q == PS_W'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + PS_W'(1);

    // Scan FSM next state: one visit per tick, SAMPLE then UPDATE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tick) state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Decode the visited channel's transition; a coincident clear suppresses
    // the count step and its event, but an illegal jump is still counted.
    always_comb begin
        prev_sel = prev_q[ptr_q];
        cnt_sel  = cnt_q[ptr_q];
        do_upd   = (state_q == S_UPDATE) && seen_q[ptr_q];
        pos_diff = gray_pos(cur_ab_q) - gray_pos(prev_sel);
        step_up  = do_upd && (pos_diff == 2'd1);
        step_dn  = do_upd && (pos_diff == 2'd3);
        illegal  = do_upd && (pos_diff == 2'd2);
        cnt_new  = step_up ? cnt_sel + CNT_W'(1) : cnt_sel - CNT_W'(1);
`ifdef ENC_SAT_EN
        cnt_step = (step_up && (cnt_sel != '1)) || (step_dn && (cnt_sel != '0));
`else
        cnt_step = step_up || step_dn;
`endif
        cnt_step   = cnt_step && !ch_clr[ptr_q];
        detent_chg = cnt_step && (cnt_new[CNT_W-1:2] != cnt_sel[CNT_W-1:2]);
    end

    // Round-robin search: first pending channel at or after last_grant+1.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = CH_W'((int'(last_q) + 1 + i) % N_CH);
            if (!arb_found && pend_q[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    assign load_en = !evt_valid_q || evt_ready;
    assign drain   = load_en && arb_found;

    // Per-channel next state; priority is clear > new event > drain.
    always_comb begin
        lost_set = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            prev_d[i] = prev_q[i];
            seen_d[i] = seen_q[i];
            pend_d[i] = pend_q[i];
            dir_d[i]  = dir_q[i];
            if ((state_q == S_UPDATE) && (ptr_q == CH_W'(i))) begin
                prev_d[i] = cur_ab_q;
                seen_d[i] = 1'b1;
                if (cnt_step) cnt_d[i] = cnt_new;
            end
            if (drain && (arb_sel == CH_W'(i))) pend_d[i] = 1'b0;
            if (detent_chg && (ptr_q == CH_W'(i))) begin
                pend_d[i] = 1'b1;
                dir_d[i]  = step_up;
                if (pend_q[i] && !(drain && (arb_sel == CH_W'(i)))) lost_set = 1'b1;
            end
            if (ch_clr[i]) begin
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
                prev_d[i] = {a_s[i], b_s[i]};
                seen_d[i] = 1'b1;
            end
        end
    end

    // Scan pointer, sampled AB, error counter and sticky lost flag.
    always_comb begin
        ptr_d    = ptr_q;
        cur_ab_d = cur_ab_q;
        if (state_q == S_SAMPLE) cur_ab_d = {a_s[ptr_q], b_s[ptr_q]};
        if (state_q == S_UPDATE) ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + CH_W'(1);
        err_d  = (illegal && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        lost_d = lost_q | lost_set;
    end

    // Event output register reloads whenever it is empty or being accepted.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_dir_d   = evt_dir_q;
        last_d      = last_q;
        if (load_en) begin
            evt_valid_d = arb_found;
            if (arb_found) begin
                evt_ch_d  = arb_sel;
                evt_dir_d = dir_q[arb_sel];
                last_d    = arb_sel;
            end
        end
    end

    // All state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cur_ab_q    <= '0;
            seen_q      <= '0;
            pend_q      <= '0;
            dir_q       <= '0;
            err_q       <= '0;
            lost_q      <= 1'b0;
            last_q      <= LAST_CH;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_dir_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                prev_q[i] <= '0;
            end
        end else begin
            presc_q     <= presc_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_ab_q    <= cur_ab_d;
            seen_q      <= seen_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
            last_q      <= last_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_dir_q   <= evt_dir_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                prev_q[i] <= prev_d[i];
            end
        end
    end

    // Read-back table padded to a power of two; unused selects read as zero.
    for (genvar g = 0; g < 2**CH_W; g++) begin : g_rd
        if (g < N_CH) begin : g_real
            assign rd_tab[g] = cnt_q[g][CNT_W-1:2];
        end else begin : g_pad
            assign rd_tab[g] = '0;
        end
    end

    assign rd_value  = rd_tab[rd_ch];
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_dir   = evt_dir_q;
    assign evt_lost  = lost_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_enc_scan_ctrl.sv
// tb_enc_scan_ctrl: table-driven vectors plus hand sequences for enc_scan_ctrl
// (N_CH=4, CNT_W=10, PRESCALE=4). Scan period is 16 cycles; channel c is
// sampled at cycle 5+4c and updated at cycle 6+4c (mod 16) after reset.
`timescale 1ns/1ps
module tb_enc_scan_ctrl;
    localparam int N_CH = 4;
    localparam int CNT_W = 10;
    localparam int SYNC_STAGES = 2;
    localparam int PRESCALE = 4;
    localparam int CH_W = 2;
`ifdef ENC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] enc_a, enc_b, ch_clr;
    logic [CH_W-1:0] rd_ch;
    logic [CNT_W-3:0] rd_value;
    logic            evt_valid, evt_ready, evt_dir, evt_lost;
    logic [CH_W-1:0] evt_ch;
    logic [7:0]      err_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    logic [CH_W:0] exp_q[$];

    typedef struct {
        int       ch;
        logic [1:0] ab;
        int       rd;
        int       err;
        bit       evt;
        bit       dir;
    } vec_t;
    vec_t tbl[18];

    enc_scan_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .ch_clr(ch_clr),
        .rd_ch(rd_ch), .rd_value(rd_value), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_ch(evt_ch), .evt_dir(evt_dir), .evt_lost(evt_lost), .err_cnt(err_cnt)
    );

    // Clock and cycle counter relative to the last reset release.
    always #5 clk = ~clk;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted event is popped and compared.
    always @(negedge clk) begin
        logic [CH_W:0] e;
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL evt_unexpected: got ch=%0d dir=%0d, expected no event (t=%0t)", evt_ch, evt_dir, $time);
            end else begin
                e = exp_q.pop_front();
                check("evt_ch", int'(evt_ch), int'(e[CH_W:1]));
                check("evt_dir", int'(evt_dir), int'(e[0]));
            end
        end
    end

    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 16 != 0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input int ch, input logic [1:0] ab);
        enc_a[CH_W'(ch)] = ab[1];
        enc_b[CH_W'(ch)] = ab[0];
    endtask

    task automatic step(input int ch, input logic [1:0] ab, input bit evt, input bit dir);
        align();
        drive_ab(ch, ab);
        if (evt) exp_q.push_back({CH_W'(ch), dir});
        wait_cyc(40);
    endtask

    task automatic cw_detent(input int ch, input bit emit);
        step(ch, 2'b01, 1'b0, 1'b0);
        step(ch, 2'b11, 1'b0, 1'b0);
        step(ch, 2'b10, 1'b0, 1'b0);
        step(ch, 2'b00, emit, 1'b1);
    endtask

    task automatic check_rd(input string name, input int ch, input int exp);
        rd_ch = CH_W'(ch);
        #1;
        check(name, int'(rd_value), exp);
    endtask

    task automatic pulse_ready();
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        wait_cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 2'b01, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{0, 2'b11, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{0, 2'b10, 0, 0, 1'b0, 1'b0};
        tbl[3]  = '{0, 2'b00, 1, 0, 1'b1, 1'b1};
        tbl[4]  = '{2, 2'b10, SAT ? 0 : 255, 0, !SAT, 1'b0};
        tbl[5]  = '{2, 2'b11, SAT ? 0 : 255, 0, 1'b0, 1'b0};
        tbl[6]  = '{2, 2'b01, SAT ? 0 : 255, 0, 1'b0, 1'b0};
        tbl[7]  = '{2, 2'b00, SAT ? 0 : 255, 0, 1'b0, 1'b0};
        tbl[8]  = '{3, 2'b01, 0, 0, 1'b0, 1'b0};
        tbl[9]  = '{3, 2'b11, 0, 0, 1'b0, 1'b0};
        tbl[10] = '{3, 2'b01, 0, 0, 1'b0, 1'b0};
        tbl[11] = '{3, 2'b00, 0, 0, 1'b0, 1'b0};
        tbl[12] = '{3, 2'b10, SAT ? 0 : 255, 0, !SAT, 1'b0};
        tbl[13] = '{3, 2'b00, 0, 0, !SAT, 1'b1};
        tbl[14] = '{1, 2'b11, 0, 1, 1'b0, 1'b0};
        tbl[15] = '{1, 2'b00, 0, 2, 1'b0, 1'b0};
        tbl[16] = '{1, 2'b10, SAT ? 0 : 255, 2, !SAT, 1'b0};
        tbl[17] = '{1, 2'b00, 0, 2, !SAT, 1'b1};

        reset = 1'b1;
        enc_a = '0;
        enc_b = '0;
        ch_clr = '0;
        rd_ch = '0;
        evt_ready = 1'b1;
        wait_cyc(3);

        // Reset values.
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_ch", int'(evt_ch), 0);
        check("rst_evt_dir", int'(evt_dir), 0);
        check("rst_evt_lost", int'(evt_lost), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        for (int c = 0; c < N_CH; c++) check_rd("rst_rd_value", c, 0);
        reset = 1'b0;

        // Table: single-channel steps with the consumer always ready.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].ch, tbl[i].ab, tbl[i].evt, tbl[i].dir);
            check_rd("tbl_rd_value", tbl[i].ch, tbl[i].rd);
            check("tbl_err_cnt", int'(err_cnt), tbl[i].err);
        end
        check("tbl_events_drained", exp_q.size(), 0);

        // Two channels complete a detent together while the consumer stalls.
        do_reset();
        evt_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            logic [1:0] seq [4];
            seq = '{2'b01, 2'b11, 2'b10, 2'b00};
            align();
            drive_ab(1, seq[s]);
            drive_ab(3, seq[s]);
            if (s == 3) begin
                exp_q.push_back({2'd1, 1'b1});
                exp_q.push_back({2'd3, 1'b1});
            end
            wait_cyc(40);
        end
        for (int k = 0; k < 5; k++) begin
            wait_cyc(10);
            check("hold_evt_valid", int'(evt_valid), 1);
            check("hold_evt_ch", int'(evt_ch), 1);
        end
        pulse_ready();
        check("arb_second_valid", int'(evt_valid), 1);
        check("arb_second_ch", int'(evt_ch), 3);
        pulse_ready();
        check("arb_empty_valid", int'(evt_valid), 0);
        check("arb_events_drained", exp_q.size(), 0);
        evt_ready = 1'b1;

        // Illegal jumps on ch0 and err_cnt saturation.
        do_reset();
        step(0, 2'b11, 1'b0, 1'b0);
        check("err_first", int'(err_cnt), 1);
        check_rd("err_rd_value", 0, 0);
        for (int k = 1; k < 260; k++) begin
            align();
            if (k == 254) check("err_254", int'(err_cnt), 254);
            drive_ab(0, (k % 2 == 1) ? 2'b00 : 2'b11);
        end
        wait_cyc(40);
        check("err_saturated", int'(err_cnt), 255);
        check_rd("err_rd_value_end", 0, 0);
        check("err_no_events", exp_q.size(), 0);

        // Clear coincident with ch0 UPDATE, then a lost event on ch1.
        do_reset();
        evt_ready = 1'b0;
        cw_detent(0, 1'b1);
        cw_detent(0, 1'b0);
        check_rd("clr_pre_rd_value", 0, 2);
        check("clr_pre_evt_ch", int'(evt_ch), 0);
        align();
        drive_ab(0, 2'b01);
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 16 != 5);
        ch_clr[0] = 1'b1;
        @(posedge clk);
        #1;
        ch_clr[0] = 1'b0;
        wait_cyc(40);
        check_rd("clr_rd_value", 0, 0);
        check("clr_no_lost", int'(evt_lost), 0);
        cw_detent(1, 1'b1);
        cw_detent(1, 1'b0);
        check("lost_flag", int'(evt_lost), 1);
        check_rd("lost_rd_value", 1, 2);
        pulse_ready();
        pulse_ready();
        wait_cyc(2);
        check("clr_no_extra_event", int'(evt_valid), 0);
        check("clr_events_drained", exp_q.size(), 0);
        check("lost_sticky", int'(evt_lost), 1);

        // Mid-scan reset with nonzero counts and a held event.
        cw_detent(2, 1'b1);
        check("pre_rst_evt_valid", int'(evt_valid), 1);
        rd_ch = 2'd1;
        reset = 1'b1;
        #1;
        check("mid_rst_evt_valid", int'(evt_valid), 0);
        check("mid_rst_evt_ch", int'(evt_ch), 0);
        check("mid_rst_evt_dir", int'(evt_dir), 0);
        check("mid_rst_evt_lost", int'(evt_lost), 0);
        check("mid_rst_err_cnt", int'(err_cnt), 0);
        check("mid_rst_rd_value", int'(rd_value), 0);
        exp_q.delete();
        enc_a = '1;
        enc_b = '1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        evt_ready = 1'b1;

        // First visit after reset with inputs at 11 only loads prev.
        wait_cyc(40);
        for (int c = 0; c < N_CH; c++) check_rd("first_visit_rd", c, 0);
        check("first_visit_err", int'(err_cnt), 0);
        check("first_visit_valid", int'(evt_valid), 0);
        step(0, 2'b10, 1'b0, 1'b0);
        step(0, 2'b00, 1'b0, 1'b0);
        step(0, 2'b01, 1'b0, 1'b0);
        step(0, 2'b11, 1'b1, 1'b1);
        check_rd("post_rst_rd", 0, 1);
        check("post_rst_events_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/enc_scan_ctrl.md
Name: enc_scan_ctrl

Overview:
Scanning controller that time-shares one quadrature-decode update path across N_CH rotary encoders on the expansion board. It synchronises the raw A/B lines and visits one channel per prescaler tick. For each visited channel it updates a per-channel position counter and posts detent-change events. A round-robin arbiter drains the events through a single valid/ready port to the host logic (display/menu FSM).

Parameters:
N_CH, 4, number of encoder channels (2..8)
CNT_W, 10, per-channel quadrature count width; detent value = count[CNT_W-1:2]
SYNC_STAGES, 2, synchroniser flops per A/B line (>=2)
PRESCALE, 16, clk cycles between scan ticks (>=4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enc_a  in  N_CH  raw encoder A lines, bit i = channel i
enc_b  in  N_CH  raw encoder B lines
ch_clr  in  N_CH  one-cycle pulse per channel: zero that channel's count
rd_ch  in  $clog2(N_CH)  channel select for rd_value
rd_value  out  CNT_W-2  detent value of rd_ch (combinational mux)
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_ch  out  $clog2(N_CH)  channel of current event
evt_dir  out  1  1 = clockwise (+), 0 = counter-clockwise (-)
evt_lost  out  1  sticky: pending event overwritten before drained
err_cnt  out  8  saturating count of illegal transitions (all channels)

Behaviour:
- Reset (async, active-high): syncs, prescaler, scan pointer, counts, pend/dir, seen flags, err_cnt, evt_lost = 0; evt_valid = 0; evt_ch = 0; evt_dir = 0; FSM = IDLE.
- Sync: each A/B line passes through SYNC_STAGES flops. Only synced values are used.
- Prescaler counts 0..PRESCALE-1 and wraps. tick = 1 for one cycle at wrap.
- FSM:
  - IDLE -> SAMPLE on tick.
  - SAMPLE: latch synced {A,B} of channel ptr -> UPDATE.
  - UPDATE: apply the transition rules below, then ptr = (ptr+1) mod N_CH -> IDLE.
  - Each channel is visited once per N_CH*PRESCALE cycles.
- Transition (prev -> cur, {A,B}):
  - 00->01, 01->11, 11->10, 10->00: +1.
  - Reverse sequence: -1.
  - Equal: no change.
  - Both bits changed: illegal; count unchanged; err_cnt += 1, saturating at 255.
  - prev := cur in every case.
- First visit after reset (seen[ch]=0): load prev only, set seen; no count change, no error.
- Count arithmetic: CNT_W-bit modulo 2^CNT_W (0 - 1 = 2^CNT_W - 1).
- Event: if count[CNT_W-1:2] changes in UPDATE, set pend[ch]=1 and dir[ch]=direction of the step. If pend[ch] was already 1 and not being drained this cycle, set evt_lost and overwrite dir.
- ch_clr[i]: count[i]=0, pend[i]=0, prev[i] := current synced AB. If coincident with UPDATE of channel i, clear wins.
- Arbiter:
  - Output register loads when evt_valid=0 or (evt_valid & evt_ready).
  - Source is the first pending channel at or after last_grant+1, mod N_CH; last_grant resets to N_CH-1.
  - The loaded channel's pend is cleared; evt_valid = 1 if any pend, else 0.
  - evt_ch/evt_dir are stable while evt_valid & !evt_ready.
  - Same-cycle set and drain of the same channel: the set wins and the channel stays pending with the new dir. This is not counted as lost.
- evt_lost clears only on reset.
- rd_value: count[rd_ch][CNT_W-1:2]. rd_ch >= N_CH returns 0.
- Latency: synced-input change to count update is at most SYNC_STAGES + N_CH*PRESCALE + 2 cycles. Count update to evt_valid is at most 1 cycle when the output register is free.

Optional Feature:
ENC_SAT_EN
- Defined: counts saturate at 0 and 2^CNT_W - 1. A step that would cross a limit is discarded, with no event and no error.
- Undefined: modulo wrap as above.

Test Plan:
- N_CH=4, PRESCALE=4, CNT_W=10. Ch0 steps 00,01,11,10,00, each held 40 cycles -> count0=4, rd_value(rd_ch=0)=1, exactly one event {ch=0, dir=1}.
- From reset, ch2 steps 00,10,11,01,00 -> count2=1020, rd_value=255, one event {ch=2, dir=0}. With ENC_SAT_EN -> count2=0, no event.
- Ch1 and ch3 each complete a CW detent simultaneously, evt_ready=0 -> evt_valid stays 1 with evt_ch=1 held 50 cycles. Pulse ready -> next evt_ch=3. Pulse ready -> evt_valid=0.
- Ch0 jumps 00->11 -> err_cnt=1, count0 unchanged, no event. 260 such jumps -> err_cnt=255.
- Ch0 at count 8 with event pending. Pulse ch_clr[0] in UPDATE of ch0 while input steps -> count0=0, pend cleared, no event emitted. Two CW detents on ch1 with evt_ready=0 throughout -> evt_lost=1.
- Assert reset for 1 cycle mid-scan with counts nonzero and evt_valid=1 -> all outputs 0 immediately. The first post-reset visit with inputs at 11 causes no count change.
